// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: takes the round-10 key and hands out
// round keys 10 down to 0, one per valid/ready transfer.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[a];
endmodule

module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [31:0]  w4, w5, w6, w7, p0, p1, p2, p3, rot, sub;

  assign {w4, w5, w6, w7} = key_reg;
  assign p3  = w7 ^ w6;
  assign p2  = w6 ^ w5;
  assign p1  = w5 ^ w4;
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
  end

  // rcon is looked up by the round being left, so round 0 never indexes it
  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p0 = w4 ^ sub ^ {rcon, 24'h0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      round   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          key_reg <= key_in;
          round   <= 4'd10;
          state   <= RUN;
        end
        RUN: if (rk_ready) begin
          if (round == 4'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            key_reg <= {p0, p1, p2, p3};
            round   <= round - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come straight from state registers; key_reg is held while stalled
  assign rk_out   = key_reg;
  assign rk_round = round;
  assign rk_valid = (state == RUN);
  assign busy     = (state == RUN);
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a FIPS-197 word-array model.

module tb_aes_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];
  int           walk_cycles;

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = xtime(x);
    end
    return r;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h00, r;
    for (int i = 1; i < 256; i++)
      if (a != 8'h00 && gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    r = 8'h63;
    for (int k = 0; k < 5; k++) r ^= (inv << k) | (inv >> (8 - k));
    return r;
  endfunction

  function automatic logic [7:0] rcon_ref(input int n);
    logic [7:0] rc = 8'h01;
    for (int j = 1; j < n; j++) rc = xtime(rc);
    return rc;
  endfunction

  // Fill w[40..43] with the round-10 key and run the FIPS-197 recurrence backwards
  task automatic gen_model(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    {w[40], w[41], w[42], w[43]} = k10;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon_ref(i/4), 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One key walk. b2b: caller is already 1 time unit into a done cycle.
  task automatic walk(input logic [127:0] key, input int pct, input bit b2b, input bit inj_start);
    int exp_r = 10, xfers = 0, cyc = 0;
    bit rdy;
    logic [127:0] prev_k;
    logic [3:0]   prev_r;
    gen_model(key);
    if (!b2b) @(negedge clk);
    start = 1'b1; key_in = key;
    @(posedge clk); #1; start = 1'b0; key_in = ~key;
    chk("first_valid", 128'(rk_valid), 128'd1);
    while (xfers < 11 && cyc < 400) begin
      if (!rk_valid) begin chk("valid_drop", 128'(rk_valid), 128'd1); break; end
      chk("round", 128'(rk_round), 128'(exp_r));
      chk("key", rk_out, exp_rk[exp_r]);
      chk("busy", 128'(busy), 128'd1);
      chk("no_done", 128'(done), 128'd0);
      rdy = ($urandom_range(99) < pct);
      rk_ready = rdy;
      if (inj_start && exp_r == 5) begin start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom}; end
      prev_k = rk_out; prev_r = rk_round;
      if (rdy) got_rk[exp_r] = rk_out;
      @(posedge clk); #1; start = 1'b0;
      cyc++;
      if (rdy) begin xfers++; exp_r--; end
      else begin
        chk("hold_key", rk_out, prev_k);
        chk("hold_round", 128'(rk_round), 128'(prev_r));
      end
    end
    rk_ready = 1'b0;
    walk_cycles = cyc;
    chk("xfers", 128'(xfers), 128'd11);
    chk("done", 128'(done), 128'd1);
    chk("done_valid", 128'(rk_valid), 128'd0);
    chk("done_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    logic [127:0] k;
    int n;
    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));

    #12;
    chk("rst_out", rk_out, 128'd0);
    chk("rst_round", 128'(rk_round), 128'd0);
    chk("rst_flags", {125'd0, rk_valid, busy, done}, 128'd0);
    @(negedge clk); rst = 1'b0;

    // FIPS-197 A.1, ready always high
    walk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, 0, 0);
    chk("a1_latency", 128'(walk_cycles), 128'd11);
    chk("a1_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("a1_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("a1_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(posedge clk); #1;
    chk("done_pulse", 128'(done), 128'd0);

    walk(128'h28fddef86da4244accc0a4fe3b316f26, 100, 0, 0);
    chk("kf_r1", got_rk[1], 128'he232fcf191129188b159e4e6d679a293);
    chk("kf_r0", got_rk[0], 128'h5468617473206d79204b756e67204675);

    // Backpressure on the A.1 key
    walk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 30, 0, 0);
    chk("bp_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Start while busy must not disturb the walk
    walk({$urandom, $urandom, $urandom, $urandom}, 60, 0, 1);

    // Reset mid-walk
    k = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); start = 1'b1; key_in = k; rk_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (rk_round != 4'd5 && n < 50) begin @(posedge clk); #1; n++; end
    chk("reach_r5", 128'(rk_round), 128'd5);
    rst = 1'b1; #1;
    chk("mid_rst_out", rk_out, 128'd0);
    chk("mid_rst_round", 128'(rk_round), 128'd0);
    chk("mid_rst_flags", {125'd0, rk_valid, busy, done}, 128'd0);
    @(negedge clk); rst = 1'b0; rk_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_nodone", {126'd0, done, rk_valid}, 128'd0);
    walk(k, 100, 0, 0);

    // Back-to-back walks, second start issued in the done cycle
    walk({$urandom, $urandom, $urandom, $urandom}, 100, 0, 0);
    walk({$urandom, $urandom, $urandom, $urandom}, 100, 1, 0);
    walk({$urandom, $urandom, $urandom, $urandom}, 50, 1, 0);

    for (int t = 0; t < 8; t++) walk({$urandom, $urandom, $urandom, $urandom}, 70, t[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
